p_predict_seq: RTL and testbench

- Initiator side of the start/done handshake used by the Kalman filter's Q engine (q_serial).
- Accepts a new 2-element state estimate and the current 2x2 covariance P.
- Drives the Q engine with the current and previous states, waits for done, then outputs P_pred = P + Q with saturation.
- Sits between the state-update stage and the covariance-predict consumer, and owns the previous-state history register.

---
 rtl/p_predict_seq_pkg.sv | 22 ++
 rtl/fxp_sat_add.sv | 31 +++
 rtl/p_predict_seq.sv | 169 ++++++++++++++++
 tb/tb_p_predict_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/p_predict_seq_pkg.sv
// Shared fixed-point format and FSM encoding for the covariance-predict initiator.
package p_predict_seq_pkg;

    localparam int FXP_N    = 16;
    localparam int FXP_FRAC = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    function automatic logic [FXP_N-1:0] fxp_max();
        return {1'b0, {(FXP_N-1){1'b1}}};
    endfunction

    function automatic logic [FXP_N-1:0] fxp_min();
        return {1'b1, {(FXP_N-1){1'b0}}};
    endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational N-bit signed saturating adder with overflow flag.
// Zero latency; no flow control.
module fxp_sat_add
    import p_predict_seq_pkg::*;
#(
    parameter int N = FXP_N
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o,
    output logic         ovf_o
);

    localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    logic [N:0] sum;

    assign sum = {a_i[N-1], a_i} + {b_i[N-1], b_i};

    // Top two bits of the N+1-bit sum disagree only when the result left the N-bit range.
    always_comb begin
        y_o   = sum[N-1:0];
        ovf_o = 1'b0;
        if (sum[N] != sum[N-1]) begin
            ovf_o = 1'b1;
            y_o   = sum[N] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/p_predict_seq.sv
// Initiator for the Q engine: latches x and P, requests Q, emits sat(P + Q).
// Latency c0+L+2 (c0+2 first sample, c0+TIMEOUT+2 on timeout); in_ready only in IDLE, no queueing.
module p_predict_seq
    import p_predict_seq_pkg::*;
#(
    parameter int N       = FXP_N,
    parameter int FRAC    = FXP_FRAC,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x00,
    input  logic [N-1:0] x01,
    input  logic [N-1:0] P11,
    input  logic [N-1:0] P12,
    input  logic [N-1:0] P21,
    input  logic [N-1:0] P22,
    output logic         q_start,
    output logic [N-1:0] q_x00_now,
    output logic [N-1:0] q_x01_now,
    output logic [N-1:0] q_x00_prev,
    output logic [N-1:0] q_x01_prev,
    input  logic         q_done,
    input  logic [N-1:0] Q11,
    input  logic [N-1:0] Q12,
    input  logic [N-1:0] Q21,
    input  logic [N-1:0] Q22,
    output logic         out_valid,
    output logic [N-1:0] Pp11,
    output logic [N-1:0] Pp12,
    output logic [N-1:0] Pp21,
    output logic [N-1:0] Pp22,
    output logic         sat,
    output logic         err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // FRAC only names the format; the sum is format-agnostic.
    if (FRAC >= N) begin : g_frac_out_of_range
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  x00_q, x01_q, prev00_q, prev01_q;
    logic [N-1:0]  p11_q, p12_q, p21_q, p22_q;
    logic [N-1:0]  pp11_q, pp12_q, pp21_q, pp22_q;
    logic          prev_vld_q, err_q, sat_q;
    logic          accept, timeout_hit, take_q;
    logic [N-1:0]  q11_s, q12_s, q21_s, q22_s;
    logic [N-1:0]  s11, s12, s21, s22;
    logic          o11, o12, o21, o22;

    // First sample also passes through REQ (without a pulse) so its output lands at c0+2.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        q_start     = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                q_start = prev_vld_q;
                cnt_d   = '0;
                state_d = prev_vld_q ? S_WAIT : S_OUT;
            end
            S_WAIT: begin
                if (q_done) begin
                    state_d = S_OUT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Q is consumed on the very edge it is captured; first sample and timeout see zero.
    assign take_q = (state_q == S_WAIT) && q_done;
    assign q11_s  = take_q ? Q11 : '0;
    assign q12_s  = take_q ? Q12 : '0;
    assign q21_s  = take_q ? Q21 : '0;
    assign q22_s  = take_q ? Q22 : '0;

    fxp_sat_add #(.N(N)) u_add11 (.a_i(p11_q), .b_i(q11_s), .y_o(s11), .ovf_o(o11));
    fxp_sat_add #(.N(N)) u_add12 (.a_i(p12_q), .b_i(q12_s), .y_o(s12), .ovf_o(o12));
    fxp_sat_add #(.N(N)) u_add21 (.a_i(p21_q), .b_i(q21_s), .y_o(s21), .ovf_o(o21));
    fxp_sat_add #(.N(N)) u_add22 (.a_i(p22_q), .b_i(q22_s), .y_o(s22), .ovf_o(o22));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x00_q      <= '0;
            x01_q      <= '0;
            prev00_q   <= '0;
            prev01_q   <= '0;
            prev_vld_q <= 1'b0;
            p11_q      <= '0;
            p12_q      <= '0;
            p21_q      <= '0;
            p22_q      <= '0;
            pp11_q     <= '0;
            pp12_q     <= '0;
            pp21_q     <= '0;
            pp22_q     <= '0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                x00_q <= x00;
                x01_q <= x01;
                p11_q <= P11;
                p12_q <= P12;
                p21_q <= P21;
                p22_q <= P22;
                err_q <= 1'b0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            // OUT is only ever entered from REQ or WAIT, so this is the entry edge.
            if (state_d == S_OUT) begin
                pp11_q <= s11;
                pp12_q <= s12;
                pp21_q <= s21;
                pp22_q <= s22;
                sat_q  <= o11 | o12 | o21 | o22;
            end
            if (state_q == S_OUT) begin
                prev00_q   <= x00_q;
                prev01_q   <= x01_q;
                prev_vld_q <= 1'b1;
            end
        end
    end

    assign q_x00_now  = x00_q;
    assign q_x01_now  = x01_q;
    assign q_x00_prev = prev00_q;
    assign q_x01_prev = prev01_q;
    assign Pp11       = pp11_q;
    assign Pp12       = pp12_q;
    assign Pp21       = pp21_q;
    assign Pp22       = pp22_q;
    assign sat        = sat_q;
    assign err        = err_q;

endmodule

// File: tb/tb_p_predict_seq.sv
// Directed and randomized checks of p_predict_seq against a sample-level reference model.
module tb_p_predict_seq;

    localparam int N       = 16;
    localparam int FRAC    = 10;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x00, x01, P11, P12, P21, P22;
    logic         q_start;
    logic [N-1:0] q_x00_now, q_x01_now, q_x00_prev, q_x01_prev;
    logic         q_done;
    logic [N-1:0] Q11, Q12, Q21, Q22;
    logic         out_valid;
    logic [N-1:0] Pp11, Pp12, Pp21, Pp22;
    logic         sat, err;

    int checks = 0;
    int errors = 0;

    // Reference model state: the history the block should be holding.
    int m_prev0 = 0;
    int m_prev1 = 0;
    bit m_prev_vld = 1'b0;

    always #5 clk = ~clk;

    p_predict_seq #(.N(N), .FRAC(FRAC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x00(x00), .x01(x01), .P11(P11), .P12(P12), .P21(P21), .P22(P22),
        .q_start(q_start), .q_x00_now(q_x00_now), .q_x01_now(q_x01_now),
        .q_x00_prev(q_x00_prev), .q_x01_prev(q_x01_prev),
        .q_done(q_done), .Q11(Q11), .Q12(Q12), .Q21(Q21), .Q22(Q22),
        .out_valid(out_valid), .Pp11(Pp11), .Pp12(Pp12), .Pp21(Pp21), .Pp22(Pp22),
        .sat(sat), .err(err)
    );

    function automatic logic [31:0] w16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return {16'h0, t};
    endfunction

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One sample: drive it, act as the Q engine with latency lat (out of 1..TIMEOUT means silent),
    // and compare latency, operands and result with the model.
    task automatic run_sample(input int x0, input int x1,
                              input int p11, input int p12, input int p21, input int p22,
                              input int q11, input int q12, input int q21, input int q22,
                              input int lat, input bit hold_in);
        int  pv[4], qv[4], ev[4];
        int  k_qs, n_qs, k_out, e_lat;
        bit  first, tmo, e_sat;
        pv = '{p11, p12, p21, p22};
        qv = '{q11, q12, q21, q22};
        first = !m_prev_vld;
        tmo   = !first && (lat < 1 || lat > TIMEOUT);
        e_sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ev[i] = clamp(pv[i] + ((first || tmo) ? 0 : qv[i]));
            if (ev[i] != pv[i] + ((first || tmo) ? 0 : qv[i])) e_sat = 1'b1;
        end
        e_lat = first ? 2 : (tmo ? TIMEOUT + 2 : lat + 2);

        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x00 = N'(x0); x01 = N'(x1);
        P11 = N'(p11); P12 = N'(p12); P21 = N'(p21); P22 = N'(p22);
        n_qs = 0; k_qs = -1; k_out = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!hold_in) in_valid = 1'b0;
            q_done = 1'b0;
            if (k == 1) check("err_cleared_on_accept", {31'b0, err}, 32'd0);
            if (q_start) begin
                n_qs++;
                if (k_qs < 0) begin
                    k_qs = k;
                    check("op_x00_now",  {16'h0, q_x00_now},  w16(x0));
                    check("op_x01_now",  {16'h0, q_x01_now},  w16(x1));
                    check("op_x00_prev", {16'h0, q_x00_prev}, w16(m_prev0));
                    check("op_x01_prev", {16'h0, q_x01_prev}, w16(m_prev1));
                end
            end
            if (k_qs > 0 && lat > 0 && k == k_qs + lat) begin
                q_done = 1'b1;
                Q11 = N'(q11); Q12 = N'(q12); Q21 = N'(q21); Q22 = N'(q22);
            end
            if (out_valid) begin
                k_out = k;
                in_valid = 1'b0;
                break;
            end
        end
        q_done = 1'b0;
        in_valid = 1'b0;
        check("out_latency", 32'(k_out), 32'(e_lat));
        check("q_start_count", 32'(n_qs), first ? 32'd0 : 32'd1);
        check("Pp11", {16'h0, Pp11}, w16(ev[0]));
        check("Pp12", {16'h0, Pp12}, w16(ev[1]));
        check("Pp21", {16'h0, Pp21}, w16(ev[2]));
        check("Pp22", {16'h0, Pp22}, w16(ev[3]));
        check("sat", {31'b0, sat}, {31'b0, e_sat});
        check("err", {31'b0, err}, {31'b0, tmo});
        @(negedge clk);
        check("out_valid_one_cycle", {31'b0, out_valid}, 32'd0);
        check("Pp11_hold", {16'h0, Pp11}, w16(ev[0]));
        m_prev0 = x0;
        m_prev1 = x1;
        m_prev_vld = 1'b1;
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; q_done = 1'b0;
        x00 = '0; x01 = '0; P11 = '0; P12 = '0; P21 = '0; P22 = '0;
        Q11 = '0; Q12 = '0; Q21 = '0; Q22 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_q_start",   {31'b0, q_start},   32'd0);
        check("rst_err",       {31'b0, err},       32'd0);
        check("rst_sat",       {31'b0, sat},       32'd0);
        check("rst_Pp22",      {16'h0, Pp22},      32'd0);
        check("rst_q_prev",    {16'h0, q_x00_prev}, 32'd0);

        // First sample, then a normal request, then saturation in both directions.
        run_sample(0, 0, 1024, 0, 0, 1024, 0, 0, 0, 0, 3, 1'b0);
        run_sample(2048, 1024, 1024, 0, 0, 1024, 2560, 0, 0, 2560, 3, 1'b0);
        run_sample(100, -200, 30000, -30000, 5, -7, 5000, -5000, 1, 1, 4, 1'b0);
        // Silent engine: timeout, then history and err recovery on the next sample.
        run_sample(-512, 777, 11, 22, 33, 44, 9, 9, 9, 9, 0, 1'b0);
        run_sample(5, 6, 100, 200, 300, 400, 1, 2, 3, 4, TIMEOUT, 1'b0);
        // in_valid held through the wait: still exactly one acceptance.
        run_sample(7, 8, 1, 1, 1, 1, 2, 2, 2, 2, 6, 1'b1);

        // Stray q_done while idle.
        @(negedge clk);
        q_done = 1'b1;
        @(negedge clk);
        q_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stray_done_no_out",   {31'b0, out_valid}, 32'd0);
            check("stray_done_no_start", {31'b0, q_start},   32'd0);
            @(negedge clk);
        end

        // Reset during WAIT aborts the request and discards history.
        in_valid = 1'b1; x00 = 16'd99; x01 = 16'd98;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_prev0 = 0; m_prev1 = 0; m_prev_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            q_done = (k == 1);
            @(negedge clk);
            check("abort_no_out",   {31'b0, out_valid}, 32'd0);
            check("abort_no_start", {31'b0, q_start},   32'd0);
        end
        q_done = 1'b0;
        check("abort_Pp11_cleared", {16'h0, Pp11}, 32'd0);
        run_sample(3, 4, 50, 60, 70, 80, 1, 1, 1, 1, 2, 1'b0);

        // Random samples; latencies beyond TIMEOUT model a silent engine.
        for (int n = 0; n < 25; n++) begin
            lat = (n % 9 == 8) ? 0 : int'($urandom_range(1, TIMEOUT + 3));
            run_sample(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
                       rnd16() / 4, rnd16() / 4, rnd16(), rnd16() / 64, lat, n[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
